// File: rtl/switch_bank.sv
// switch_bank: MMIO switch reader with per-group synchroniser, debounce and packed 32-bit data words.
// Define SWITCH_BANK_IRQ_EN to build the change-flag, mask and IRQ registers.
module switch_bank #(
  parameter int GROUPS       = 8,
  parameter int GROUP_W      = 8,
  parameter int DEBOUNCE_CYC = 16,
  parameter int ADDR_W       = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [GROUPS*GROUP_W-1:0] sw_in,
  input  logic [ADDR_W-1:0]         innerADDR,
  input  logic                      WE,
  input  logic [31:0]               WD,
  output logic [31:0]               RD,
  output logic                      IRQ
);

  localparam int TW = GROUPS * GROUP_W;
  localparam int NW = TW / 32;
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [TW-1:0]     sync1, sync2, stable;
  logic [CW-1:0]     cnt [GROUPS];
  logic [GROUPS-1:0] upd;
  logic [31:0]       rd_next;
  logic              unused_wd;

  assign unused_wd = ^{WE, WD};

  // A group accepts on the DEBOUNCE_CYC-th consecutive cycle its synced value differs from stable.
  always_comb begin
    upd = '0;
    for (int g = 0; g < GROUPS; g++) begin
      upd[g] = (sync2[g*GROUP_W +: GROUP_W] != stable[g*GROUP_W +: GROUP_W]) &&
               (cnt[g] == CNT_LAST);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int g = 0; g < GROUPS; g++) cnt[g] <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      for (int g = 0; g < GROUPS; g++) begin
        if (sync2[g*GROUP_W +: GROUP_W] == stable[g*GROUP_W +: GROUP_W]) begin
          cnt[g] <= '0;
        end else if (upd[g]) begin
          stable[g*GROUP_W +: GROUP_W] <= sync2[g*GROUP_W +: GROUP_W];
          cnt[g] <= '0;
        end else begin
          cnt[g] <= cnt[g] + 1'b1;
        end
      end
    end
  end

`ifdef SWITCH_BANK_IRQ_EN
  logic [GROUPS-1:0] flags, mask, flags_next, mask_next;
  logic              wr_flags, wr_mask;

  assign wr_flags = WE && (innerADDR == ADDR_W'(NW));
  assign wr_mask  = WE && (innerADDR == ADDR_W'(NW + 1));

  // A new acceptance beats a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    flags_next = flags;
    mask_next  = mask;
    if (wr_flags) flags_next = flags & ~WD[GROUPS-1:0];
    flags_next = flags_next | upd;
    if (wr_mask) mask_next = WD[GROUPS-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flags <= '0;
      mask  <= '0;
      IRQ   <= 1'b0;
    end else begin
      flags <= flags_next;
      mask  <= mask_next;
      IRQ   <= |(flags_next & mask_next);
    end
  end
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NW; k++) begin
      if (innerADDR == ADDR_W'(k)) rd_next = stable[k*32 +: 32];
    end
`ifdef SWITCH_BANK_IRQ_EN
    if (innerADDR == ADDR_W'(NW))     rd_next = 32'(flags);
    if (innerADDR == ADDR_W'(NW + 1)) rd_next = 32'(mask);
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) RD <= '0;
    else     RD <= rd_next;
  end

endmodule

// File: tb/tb_switch_bank.sv
// Self-checking bench for switch_bank (8 groups x 8 bits, 4-cycle debounce) with a behavioural model.
// Follows the RTL build: SWITCH_BANK_IRQ_EN selects the flag/IRQ scenarios or the disabled-feature scenario.
module tb_switch_bank;
  localparam int G   = 8;
  localparam int W   = 8;
  localparam int DEB = 4;

  logic        CLK;
  logic        RST;
  logic [63:0] sw_in;
  logic [2:0]  innerADDR;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int n_cmp = 0;
  int n_err = 0;

  switch_bank #(.GROUPS(G), .GROUP_W(W), .DEBOUNCE_CYC(DEB), .ADDR_W(3)) dut (
    .CLK(CLK), .RST(RST), .sw_in(sw_in), .innerADDR(innerADDR),
    .WE(WE), .WD(WD), .RD(RD), .IRQ(IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: switch history queue, per-group mismatch streaks, flag/mask bytes.
  logic [63:0] hist [$] = '{64'd0, 64'd0};
  logic [7:0]  st_m [G];
  int          streak [G];
  logic [7:0]  flags_m, mask_m, upd_m;
  logic [63:0] synced_m;
  logic [31:0] exp_rd;
  logic        exp_irq;

  function automatic logic [31:0] model_word(input logic [2:0] a);
    case (a)
      3'd0: return {st_m[3], st_m[2], st_m[1], st_m[0]};
      3'd1: return {st_m[7], st_m[6], st_m[5], st_m[4]};
`ifdef SWITCH_BANK_IRQ_EN
      3'd2: return {24'd0, flags_m};
      3'd3: return {24'd0, mask_m};
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist = '{64'd0, 64'd0};
      for (int g = 0; g < G; g++) begin st_m[g] = 8'd0; streak[g] = 0; end
      flags_m = 8'd0;
      mask_m  = 8'd0;
      exp_rd  = 32'd0;
      exp_irq = 1'b0;
    end else begin
      exp_rd = model_word(innerADDR);
      synced_m = hist.pop_front();
      hist.push_back(sw_in);
      upd_m = 8'd0;
      for (int g = 0; g < G; g++) begin
        if (synced_m[g*W +: W] != st_m[g]) begin
          streak[g] = streak[g] + 1;
          if (streak[g] == DEB) begin
            st_m[g] = synced_m[g*W +: W];
            streak[g] = 0;
            upd_m[g] = 1'b1;
          end
        end else begin
          streak[g] = 0;
        end
      end
`ifdef SWITCH_BANK_IRQ_EN
      if (WE && innerADDR == 3'd2) flags_m = flags_m & ~WD[7:0];
      flags_m = flags_m | upd_m;
      if (WE && innerADDR == 3'd3) mask_m = WD[7:0];
      exp_irq = |(flags_m & mask_m);
`else
      exp_irq = 1'b0;
`endif
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; WE = 1'b0; sw_in = '0; innerADDR = '0; WD = '0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic rd_word(input logic [2:0] a, output logic [31:0] d);
    innerADDR = a; WE = 1'b0;
    @(negedge CLK);
    d = RD;
  endtask

  task automatic wr_word(input logic [2:0] a, input logic [31:0] d);
    innerADDR = a; WE = 1'b1; WD = d;
    @(negedge CLK);
    WE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    wr_word(3'd3, 32'hFF);
    sw_in = {$urandom, $urandom} | 64'h1;
    innerADDR = 3'd0;
    repeat (12) @(negedge CLK);
    n_cmp++;
    if (RD !== exp_rd) begin n_err++; $display("FAIL pre_reset_rd: RD=%h expected %h", RD, exp_rd); end
    n_cmp++;
    if (IRQ !== exp_irq) begin n_err++; $display("FAIL pre_reset_irq: IRQ=%b expected %b", IRQ, exp_irq); end
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (RD !== 32'd0) begin n_err++; $display("FAIL async_reset_rd: RD=%h expected 00000000", RD); end
    n_cmp++;
    if (IRQ !== 1'b0) begin n_err++; $display("FAIL async_reset_irq: IRQ=%b expected 0", IRQ); end
    @(negedge CLK);
    sw_in = '0;
    RST = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_word(3'(a), d);
      n_cmp++;
      if (d !== 32'd0) begin n_err++; $display("FAIL reset_read addr%0d: RD=%h expected 00000000", a, d); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] e;
    do_reset();
    innerADDR = 3'd0;
    sw_in = 64'hA5;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      e = (i >= 7) ? 32'h000000A5 : 32'd0;
      n_cmp++;
      if (RD !== e) begin n_err++; $display("FAIL latency cyc%0d: RD=%h expected %h", i, RD, e); end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    do_reset();
    innerADDR = 3'd0;
    for (int r = 0; r < 4; r++) begin
      sw_in[15:8] = (r % 2 == 0) ? 8'hFF : 8'h00;
      repeat (3) @(negedge CLK);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (RD !== 32'd0) begin n_err++; $display("FAIL glitch_data cyc%0d: RD=%h expected 00000000", i, RD); end
    end
    rd_word(3'd2, d);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL glitch_flags: RD=%h expected 00000000", d); end
  endtask

`ifdef SWITCH_BANK_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    do_reset();
    wr_word(3'd3, 32'h10);
    sw_in[39:32] = 8'h3C;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (IRQ !== (i >= 6)) begin n_err++; $display("FAIL irq_rise cyc%0d: IRQ=%b expected %b", i, IRQ, (i >= 6)); end
    end
    rd_word(3'd1, d);
    n_cmp++;
    if (d !== 32'h3C) begin n_err++; $display("FAIL irq_data: RD=%h expected 0000003c", d); end
    rd_word(3'd2, d);
    n_cmp++;
    if (d !== 32'h10) begin n_err++; $display("FAIL irq_flags: RD=%h expected 00000010", d); end
    rd_word(3'd3, d);
    n_cmp++;
    if (d !== 32'h10) begin n_err++; $display("FAIL irq_mask: RD=%h expected 00000010", d); end
    wr_word(3'd2, 32'h10);
    n_cmp++;
    if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_clear: IRQ=%b expected 0", IRQ); end
    rd_word(3'd2, d);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL flags_cleared: RD=%h expected 00000000", d); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    do_reset();
    sw_in[7:0] = 8'h5A;
    repeat (5) @(negedge CLK);
    wr_word(3'd2, 32'h1);
    rd_word(3'd2, d);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL set_wins: RD=%h expected 00000001", d); end
    wr_word(3'd2, 32'h1);
    rd_word(3'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL w1c_alone: RD=%h expected 00000000", d); end
  endtask
`else
  task automatic test_noirq();
    logic [31:0] d;
    do_reset();
    wr_word(3'd3, 32'h10);
    sw_in[39:32] = 8'h3C;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (IRQ !== 1'b0) begin n_err++; $display("FAIL noirq_irq cyc%0d: IRQ=%b expected 0", i, IRQ); end
    end
    rd_word(3'd1, d);
    n_cmp++;
    if (d !== 32'h3C) begin n_err++; $display("FAIL noirq_data: RD=%h expected 0000003c", d); end
    rd_word(3'd2, d);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL noirq_flags: RD=%h expected 00000000", d); end
    rd_word(3'd3, d);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL noirq_mask: RD=%h expected 00000000", d); end
  endtask
`endif

  task automatic test_random();
    int g;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      n_cmp++;
      if (RD !== exp_rd) begin n_err++; $display("FAIL random_rd cyc%0d: RD=%h expected %h", i, RD, exp_rd); end
      n_cmp++;
      if (IRQ !== exp_irq) begin n_err++; $display("FAIL random_irq cyc%0d: IRQ=%b expected %b", i, IRQ, exp_irq); end
      RST = (i % 1000 == 999);
      if ($urandom_range(0, 4) == 0) begin
        g = $urandom_range(0, G - 1);
        sw_in[g*W +: W] = 8'($urandom);
      end
      innerADDR = 3'($urandom_range(0, 7));
      WE = ($urandom_range(0, 5) == 0);
      WD = $urandom;
      @(negedge CLK);
    end
    RST = 1'b0;
    WE = 1'b0;
  endtask

  initial begin
    RST = 1'b1; sw_in = '0; innerADDR = '0; WE = 1'b0; WD = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
`ifdef SWITCH_BANK_IRQ_EN
    test_irq();
    test_set_wins();
`else
    test_noirq();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
